// File: rtl/id_stage_p.sv
// MIPS instruction-decode stage: 32-entry register file with optional write-back
// bypass, load-use hazard detection, and a registered valid/ready output slot.
module id_stage_p #(
  parameter int unsigned DATA_W = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       ins,
  input  logic [DATA_W-1:0] npc_i,
  input  logic              wb_en,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_mem_read,
  input  logic [4:0]        ex_dst_reg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        op,
  output logic [5:0]        func,
  output logic [25:0]       jpc,
  output logic [4:0]        dst_reg,
  output logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] npc_o,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              stall
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [5:0] op_w;
  logic [4:0] rs, rt, rd;
  assign op_w = ins[31:26];
  assign rs   = ins[25:21];
  assign rt   = ins[20:16];
  assign rd   = ins[15:11];

  // Register file
  logic [DATA_W-1:0] rf_q [32];

  // NOTE: the register file is a flop array with async reset because every entry
  // must read zero straight out of reset; it cannot map onto a RAM macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_reg != 5'd0) begin
      rf_q[wb_reg] <= wb_data;
    end
  end

  logic [DATA_W-1:0] rs_val, rt_val;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rs_val = rf_q[rs];
    rt_val = rf_q[rt];
    if (rs == 5'd0)                                   rs_val = '0;
    else if (FWD_EN && wb_en && wb_reg == rs)         rs_val = wb_data;
    if (rt == 5'd0)                                   rt_val = '0;
    else if (FWD_EN && wb_en && wb_reg == rt)         rt_val = wb_data;
  end

  // Decode
  logic              rw_d, mr_d, mw_d;
  logic [4:0]        dst_d;
  logic [DATA_W-1:0] imm_d;

  always_comb begin
    rw_d  = 1'b0;
    mr_d  = 1'b0;
    mw_d  = 1'b0;
    dst_d = 5'd0;
    unique case (op_w)
      OP_RTYPE: begin rw_d = 1'b1; dst_d = rd; end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        rw_d = 1'b1; dst_d = rt;
      end
      OP_LW, OP_LB: begin rw_d = 1'b1; mr_d = 1'b1; dst_d = rt; end
      OP_SW, OP_SB: mw_d = 1'b1;
      OP_JAL:       begin rw_d = 1'b1; dst_d = 5'd31; end
      default: ;
    endcase
  end

  always_comb begin
    imm_d = DATA_W'($signed(ins[15:0]));
    if (op_w == OP_ANDI || op_w == OP_ORI || op_w == OP_XORI)
      imm_d = DATA_W'(ins[15:0]);
    else if (op_w == OP_LUI)
      imm_d = DATA_W'({ins[15:0], 16'h0000});
  end

  // Handshake and hazard
  logic out_valid_q, out_valid_d;
  logic adv, hazard, load;

  assign adv    = out_ready | ~out_valid_q;
  assign hazard = ex_mem_read && ex_dst_reg != 5'd0 &&
                  (ex_dst_reg == rs || ex_dst_reg == rt);
  assign stall  = in_valid & hazard;
  // Flush consumes whatever is presented, even a hazarded or back-pressured one.
  assign in_ready = rst_n & (flush | (adv & ~hazard));
  assign load     = adv & in_valid & ~hazard & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    if (flush)    out_valid_d = 1'b0;
    else if (adv) out_valid_d = in_valid & ~hazard;
  end

  logic [5:0]        op_q, func_q;
  logic [25:0]       jpc_q;
  logic [4:0]        dst_q;
  logic [DATA_W-1:0] imm_q, a_q, b_q, npc_q;
  logic              rw_q, mr_q, mw_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      func_q      <= '0;
      jpc_q       <= '0;
      dst_q       <= '0;
      imm_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      npc_q       <= '0;
      rw_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (load) begin
        op_q   <= op_w;
        func_q <= ins[5:0];
        jpc_q  <= ins[25:0];
        dst_q  <= dst_d;
        imm_q  <= imm_d;
        a_q    <= rs_val;
        b_q    <= rt_val;
        npc_q  <= npc_i;
        rw_q   <= rw_d;
        mr_q   <= mr_d;
        mw_q   <= mw_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign op        = op_q;
  assign func      = func_q;
  assign jpc       = jpc_q;
  assign dst_reg   = dst_q;
  assign imm       = imm_q;
  assign data_a    = a_q;
  assign data_b    = b_q;
  assign npc_o     = npc_q;
  // Controls are masked so a held bubble can never write state downstream.
  assign reg_write = out_valid_q & rw_q;
  assign mem_read  = out_valid_q & mr_q;
  assign mem_write = out_valid_q & mw_q;

endmodule

// File: tb/tb_id_stage_p.sv
// Directed bench for id_stage_p: one instance with bypass enabled, one without,
// sharing all inputs.
module tb_id_stage_p;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready, wb_en, ex_mem_read;
  logic [31:0] ins, npc_i, wb_data;
  logic [4:0]  wb_reg, ex_dst_reg;

  logic        in_ready, out_valid, reg_write, mem_read, mem_write, stall;
  logic [5:0]  op, func;
  logic [25:0] jpc;
  logic [4:0]  dst_reg;
  logic [31:0] imm, data_a, data_b, npc_o;

  logic        n_in_ready, n_out_valid, n_reg_write, n_mem_read, n_mem_write, n_stall;
  logic [5:0]  n_op, n_func;
  logic [25:0] n_jpc;
  logic [4:0]  n_dst_reg;
  logic [31:0] n_imm, n_data_a, n_data_b, n_npc_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  id_stage_p #(.DATA_W(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ins(ins), .npc_i(npc_i), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .func(func), .jpc(jpc),
    .dst_reg(dst_reg), .imm(imm), .data_a(data_a), .data_b(data_b), .npc_o(npc_o),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .stall(stall)
  );

  id_stage_p #(.DATA_W(32), .FWD_EN(1'b0)) dut_nofwd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .ins(ins), .npc_i(npc_i), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_dst_reg(ex_dst_reg), .flush(flush),
    .out_valid(n_out_valid), .out_ready(out_ready), .op(n_op), .func(n_func),
    .jpc(n_jpc), .dst_reg(n_dst_reg), .imm(n_imm), .data_a(n_data_a),
    .data_b(n_data_b), .npc_o(n_npc_o), .reg_write(n_reg_write),
    .mem_read(n_mem_read), .mem_write(n_mem_write), .stall(n_stall)
  );

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
    wb_reg = 5'd0; wb_data = '0; ex_mem_read = 1'b0; ex_dst_reg = 5'd0;
    ins = '0; npc_i = '0;
  endtask

  task automatic test_reset();
    logic [191:0] all_a, all_b;
    rst_n = 1'b0;
    idle();
    in_valid = 1'b1; ins = 32'h20A6FFFF;
    repeat (2) @(posedge clk);
    #1;
    all_a = {in_ready, out_valid, reg_write, mem_read, mem_write, op, func, jpc,
             dst_reg, imm, data_a, data_b, npc_o};
    all_b = {n_in_ready, n_out_valid, n_reg_write, n_mem_read, n_mem_write, n_op,
             n_func, n_jpc, n_dst_reg, n_imm, n_data_a, n_data_b, n_npc_o};
    chk_cnt++; if (all_a !== '0) $display("FAIL reset_outputs: got %h exp 0", all_a); else pass_cnt++;
    chk_cnt++; if (all_b !== '0) $display("FAIL reset_outputs_nofwd: got %h exp 0", all_b); else pass_cnt++;
    chk_cnt++; if ({stall, n_stall} !== 2'b00) $display("FAIL reset_stall: got %b exp 00", {stall, n_stall}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    wb_en = 1'b1; wb_reg = 5'd5; wb_data = 32'h1234;
    @(negedge clk);
    idle();
    in_valid = 1'b1; ins = 32'h20A6FFFF; npc_i = 32'h104;  // ADDI r6,r5,-1
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL wr_in_ready: got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL wr_valid: got %b exp 1", out_valid); else pass_cnt++;
    chk_cnt++; if (data_a !== 32'h1234) $display("FAIL wr_data_a: got %h exp 00001234", data_a); else pass_cnt++;
    chk_cnt++; if (imm !== 32'hFFFFFFFF) $display("FAIL wr_imm: got %h exp ffffffff", imm); else pass_cnt++;
    chk_cnt++; if (dst_reg !== 5'd6) $display("FAIL wr_dst: got %0d exp 6", dst_reg); else pass_cnt++;
    chk_cnt++; if (reg_write !== 1'b1) $display("FAIL wr_reg_write: got %b exp 1", reg_write); else pass_cnt++;
    chk_cnt++; if (op !== 6'h08 || npc_o !== 32'h104) $display("FAIL wr_op_npc: got %h/%h exp 08/00000104", op, npc_o); else pass_cnt++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_reg = 5'd7; wb_data = 32'h55;
    @(negedge clk);
    wb_data = 32'hAA;
    in_valid = 1'b1; ins = 32'h00E74020;  // ADD r8,r7,r7
    @(posedge clk); #1;
    chk_cnt++; if (data_a !== 32'hAA || data_b !== 32'hAA) $display("FAIL byp_fwd: got %h/%h exp aa/aa", data_a, data_b); else pass_cnt++;
    chk_cnt++; if (n_data_a !== 32'h55 || n_data_b !== 32'h55) $display("FAIL byp_nofwd: got %h/%h exp 55/55", n_data_a, n_data_b); else pass_cnt++;
    chk_cnt++; if (dst_reg !== 5'd8 || reg_write !== 1'b1 || func !== 6'h20) $display("FAIL byp_rtype: got dst=%0d rw=%b func=%h exp 8/1/20", dst_reg, reg_write, func); else pass_cnt++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_hazard();
    ex_mem_read = 1'b1; ex_dst_reg = 5'd3;
    in_valid = 1'b1; ins = 32'h8C640000;  // LW r4,0(r3)
    #1;
    chk_cnt++; if (stall !== 1'b1 || in_ready !== 1'b0) $display("FAIL hz_stall: got stall=%b rdy=%b exp 1/0", stall, in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0 || mem_read !== 1'b0) $display("FAIL hz_bubble: got v=%b mr=%b exp 0/0", out_valid, mem_read); else pass_cnt++;
    @(negedge clk);
    ex_dst_reg = 5'd0;  // load into r0 never hazards
    #1;
    chk_cnt++; if (stall !== 1'b0 || in_ready !== 1'b1) $display("FAIL hz_r0: got stall=%b rdy=%b exp 0/1", stall, in_ready); else pass_cnt++;
    ex_mem_read = 1'b0; ex_dst_reg = 5'd3;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b1 || mem_read !== 1'b1 || dst_reg !== 5'd4) $display("FAIL hz_issue: got v=%b mr=%b dst=%0d exp 1/1/4", out_valid, mem_read, dst_reg); else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    idle();
    out_ready = 1'b0;
    in_valid = 1'b1; ins = 32'h340900F0;  // ORI r9,r0,0xF0
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b exp 0", i, in_ready); else pass_cnt++;
      @(posedge clk); #1;
      chk_cnt++; if (out_valid !== 1'b1 || dst_reg !== 5'd4 || mem_read !== 1'b1 || imm !== 32'h0)
        $display("FAIL bp_hold[%0d]: got v=%b dst=%0d mr=%b imm=%h exp 1/4/1/0", i, out_valid, dst_reg, mem_read, imm);
      else pass_cnt++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b exp 1", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (dst_reg !== 5'd9 || imm !== 32'hF0 || reg_write !== 1'b1 || mem_read !== 1'b0)
      $display("FAIL bp_load: got dst=%0d imm=%h rw=%b mr=%b exp 9/f0/1/0", dst_reg, imm, reg_write, mem_read);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_flush();
    idle();
    out_ready = 1'b0; flush = 1'b1;
    in_valid = 1'b1; ins = 32'h20A20001;  // ADDI r2,r5,1 while r5 is a pending load
    ex_mem_read = 1'b1; ex_dst_reg = 5'd5;
    #1;
    chk_cnt++; if (in_ready !== 1'b1 || stall !== 1'b1) $display("FAIL fl_ready: got rdy=%b stall=%b exp 1/1", in_ready, stall); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0 || reg_write !== 1'b0) $display("FAIL fl_drop: got v=%b rw=%b exp 0/0", out_valid, reg_write); else pass_cnt++;
    @(negedge clk);
    idle();
  endtask

  task automatic test_decode();
    logic [31:0] v_ins [7];
    logic [4:0]  v_dst [7];
    logic [31:0] v_imm [7];
    logic [2:0]  v_ctl [7];  // {reg_write, mem_read, mem_write}
    v_ins[0] = 32'h3C038001; v_dst[0] = 5'd3;  v_imm[0] = 32'h80010000; v_ctl[0] = 3'b100; // LUI
    v_ins[1] = 32'hAC44FFFC; v_dst[1] = 5'd0;  v_imm[1] = 32'hFFFFFFFC; v_ctl[1] = 3'b001; // SW
    v_ins[2] = 32'h0C123456; v_dst[2] = 5'd31; v_imm[2] = 32'h00003456; v_ctl[2] = 3'b100; // JAL
    v_ins[3] = 32'h10220010; v_dst[3] = 5'd0;  v_imm[3] = 32'h00000010; v_ctl[3] = 3'b000; // BEQ
    v_ins[4] = 32'h80250003; v_dst[4] = 5'd5;  v_imm[4] = 32'h00000003; v_ctl[4] = 3'b110; // LB
    v_ins[5] = 32'h3826FFFF; v_dst[5] = 5'd6;  v_imm[5] = 32'h0000FFFF; v_ctl[5] = 3'b100; // XORI
    v_ins[6] = 32'hFC008000; v_dst[6] = 5'd0;  v_imm[6] = 32'hFFFF8000; v_ctl[6] = 3'b000; // unknown
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ins = v_ins[i];
      @(posedge clk); #1;
      chk_cnt++;
      if (out_valid !== 1'b1 || dst_reg !== v_dst[i] || imm !== v_imm[i] ||
          {reg_write, mem_read, mem_write} !== v_ctl[i] || op !== v_ins[i][31:26] || jpc !== v_ins[i][25:0])
        $display("FAIL dec[%0d]: got v=%b dst=%0d imm=%h ctl=%b op=%h jpc=%h exp dst=%0d imm=%h ctl=%b",
                 i, out_valid, dst_reg, imm, {reg_write, mem_read, mem_write}, op, jpc, v_dst[i], v_imm[i], v_ctl[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_r0_and_midreset();
    wb_en = 1'b1; wb_reg = 5'd0; wb_data = 32'hFFFF;
    @(negedge clk);
    in_valid = 1'b1; ins = 32'h20020005;  // ADDI r2,r0,5 with r0 write still asserted
    @(posedge clk); #1;
    chk_cnt++; if (data_a !== 32'h0 || n_data_a !== 32'h0 || imm !== 32'h5) $display("FAIL r0_read: got %h/%h imm=%h exp 0/0/5", data_a, n_data_a, imm); else pass_cnt++;
    @(negedge clk);
    idle();
    in_valid = 1'b1; ins = 32'h00E74020;
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++; if ({out_valid, reg_write, in_ready, dst_reg, imm, data_a, data_b, npc_o} !== '0)
      $display("FAIL midreset_async: got v=%b rw=%b rdy=%b dst=%0d imm=%h a=%h exp all 0", out_valid, reg_write, in_ready, dst_reg, imm, data_a);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midreset_lost: got %b exp 0", out_valid); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    in_valid = 1'b1; ins = 32'h20A60000;  // ADDI r6,r5,0: r5 was cleared by reset
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b1 || data_a !== 32'h0) $display("FAIL midreset_rf: got v=%b a=%h exp 1/0", out_valid, data_a); else pass_cnt++;
    @(negedge clk);
    ins = 32'h34018000;  // ORI r1,r0,0x8000
    @(posedge clk); #1;
    chk_cnt++; if (imm !== 32'h00008000 || dst_reg !== 5'd1 || reg_write !== 1'b1) $display("FAIL ori_zext: got imm=%h dst=%0d rw=%b exp 00008000/1/1", imm, dst_reg, reg_write); else pass_cnt++;
    @(negedge clk);
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_hazard();
    test_back_pressure();
    test_flush();
    test_decode();
    test_r0_and_midreset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion exp finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
